// File: rtl/npu_act_pkg.sv
// Shared definitions for the NPU activation unit: per-beat mode codes, fixed-point ONE and
// the signed saturation helpers used by the linear/relu path.
package npu_act_pkg;

  localparam logic [1:0] ACT_TANH = 2'd0;
  localparam logic [1:0] ACT_LIN  = 2'd1;
  localparam logic [1:0] ACT_RELU = 2'd2;
  localparam logic [1:0] ACT_LOGI = 2'd3;

  function automatic int unsigned one_q(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

  // True when v does not fit a w-bit two's-complement result.
  function automatic logic sat_hit(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/npu_act_lut.sv
// Synchronous-read tanh ROM holding the tansig table: entry i = round(ONE * tanh(i * 2^LUT_SHIFT / 2^(2*FRAC_W))).
// Contents are generated at elaboration; the read register holds its value while en is low.
module npu_act_lut
  import npu_act_pkg::*;
#(
  parameter int LUT_AW    = 11,
  parameter int DOUT_W    = 16,
  parameter int FRAC_W    = 7,
  parameter int LUT_SHIFT = 5
) (
  input  logic              CLK,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [DOUT_W-1:0] data
);

  // Integer-only tanh: e^(2x) in Q20 via argument halving, Taylor series and repeated squaring.
  function automatic int tansig_entry(input int idx);
    longint y;
    longint e;
    longint term;
    longint num;
    longint den;
    int     k;
    y = (longint'(idx) <<< (LUT_SHIFT + 21)) >>> (2 * FRAC_W);
    k = 0;
    while (y > (64'sd1 <<< 19)) begin
      y = y >>> 1;
      k++;
    end
    e    = 64'sd1 <<< 20;
    term = 64'sd1 <<< 20;
    for (int n = 1; n <= 10; n++) begin
      term = ((term * y) >>> 20) / longint'(n);
      e    = e + term;
    end
    for (int j = 0; j < k; j++) begin
      e = (e * e) >>> 20;
    end
    num = (e - (64'sd1 <<< 20)) <<< (FRAC_W + 1);
    den = e + (64'sd1 <<< 20);
    return int'(((num / den) + 64'sd1) >>> 1);
  endfunction

  logic [DOUT_W-1:0] rom [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    localparam logic [DOUT_W-1:0] ENTRY = DOUT_W'(tansig_entry(i));
    assign rom[i] = ENTRY;
  end

  always_ff @(posedge CLK) begin
    if (en) data <= rom[addr];
  end

endmodule

// File: rtl/npu_activation_unit.sv
// Pipelined activation stage (tanh / saturating linear / relu / logistic) with valid/ready flow
// control and channel tag pass-through. Define NPU_ACT_SATCNT_EN to build the clamp-event counter.
module npu_activation_unit
  import npu_act_pkg::*;
#(
  parameter int          DIN_W     = 48,
  parameter int          DOUT_W    = 16,
  parameter int          FRAC_W    = 7,
  parameter int          LUT_AW    = 11,
  parameter int          LUT_SHIFT = 5,
  parameter int unsigned SAT_THR   = 32'hC7A0,
  parameter int          CH_W      = 3
) (
  input  logic                     CLK,
  input  logic                     npu_rst_n,
  input  logic signed [DIN_W-1:0]  din,
  input  logic [1:0]               din_mode,
  input  logic [CH_W-1:0]          din_ch,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic [CH_W-1:0]          dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  input  logic                     sat_clr,
  output logic [15:0]              sat_count
);

  localparam logic signed [DOUT_W-1:0] ONE_Q    = DOUT_W'(one_q(FRAC_W));
  localparam logic signed [DOUT_W-1:0] HALF_Q   = ONE_Q >>> 1;
  localparam logic [DIN_W:0]           THR_TANH = (DIN_W+1)'(SAT_THR);
  localparam logic [DIN_W:0]           THR_LOGI = (DIN_W+1)'(2 * SAT_THR);

  logic adv;

  logic                     neg;
  logic signed [DIN_W:0]    din_x;
  logic [DIN_W:0]           a;
  logic                     is_logi;
  logic [LUT_AW-1:0]        lut_addr;
  logic                     thr_hit;
  logic signed [63:0]       din_sx;
  logic signed [63:0]       lin_x;
  logic signed [DOUT_W-1:0] lin_q;
  logic                     lin_hit;

  logic                     vld_p0;
  logic [1:0]               mode_p0;
  logic [CH_W-1:0]          ch_p0;
  logic                     neg_p0;
  logic                     thr_p0;
  logic signed [DOUT_W-1:0] lin_p0;
  logic                     lin_sat_p0;
  logic [DOUT_W-1:0]        lut_p1;

  logic signed [DOUT_W-1:0] mag;
  logic signed [DOUT_W-1:0] t;
  logic signed [DOUT_W-1:0] res;
  logic                     hit;
  logic                     sat_p2;

  // The whole pipeline moves as one unit whenever the output register is free or being drained.
  assign adv       = ~dout_valid | dout_ready;
  assign din_ready = adv;

  always_comb begin
    neg     = din[DIN_W-1];
    din_x   = {din[DIN_W-1], din};
    a       = neg ? -din_x : din_x;
    is_logi = (din_mode == ACT_LOGI);
    // Logistic evaluates tanh(din/2): one extra address shift and a doubled clamp threshold.
    lut_addr = is_logi ? a[LUT_SHIFT+LUT_AW:LUT_SHIFT+1] : a[LUT_SHIFT+LUT_AW-1:LUT_SHIFT];
    thr_hit  = is_logi ? (a > THR_LOGI) : (a > THR_TANH);
    din_sx   = {{(64-DIN_W){din[DIN_W-1]}}, din};
    lin_x    = din_sx >>> FRAC_W;
    lin_hit  = sat_hit(lin_x, DOUT_W);
    lin_q    = DOUT_W'(sat_clip(lin_x, DOUT_W));
    if ((din_mode == ACT_RELU) && neg) begin
      lin_q   = '0;
      lin_hit = 1'b0;
    end
  end

  // ---- S0: beat capture; LUT read issued on the same edge (S1 data) ----
  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) vld_p0 <= 1'b0;
    else if (adv)   vld_p0 <= din_valid;
  end

  always_ff @(posedge CLK) begin
    if (adv) begin
      mode_p0    <= din_mode;
      ch_p0      <= din_ch;
      neg_p0     <= neg;
      thr_p0     <= thr_hit;
      lin_p0     <= lin_q;
      lin_sat_p0 <= lin_hit;
    end
  end

  npu_act_lut #(
    .LUT_AW    (LUT_AW),
    .DOUT_W    (DOUT_W),
    .FRAC_W    (FRAC_W),
    .LUT_SHIFT (LUT_SHIFT)
  ) u_lut (
    .CLK  (CLK),
    .en   (adv),
    .addr (lut_addr),
    .data (lut_p1)
  );

  always_comb begin
    mag = thr_p0 ? ONE_Q : $signed(lut_p1);
    t   = neg_p0 ? -mag : mag;
    res = t;
    hit = thr_p0;
    case (mode_p0)
      ACT_TANH: ;
      ACT_LOGI: res = HALF_Q + (t >>> 1);
      ACT_LIN, ACT_RELU: begin
        res = lin_p0;
        hit = lin_sat_p0;
      end
    endcase
  end

  // ---- S2: output register ----
  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      sat_p2     <= 1'b0;
    end else if (adv) begin
      dout_valid <= vld_p0;
      sat_p2     <= vld_p0 & hit;
      if (vld_p0) begin
        dout    <= res;
        dout_ch <= ch_p0;
      end
    end
  end

`ifdef NPU_ACT_SATCNT_EN
  always_ff @(posedge CLK or negedge npu_rst_n) begin
    if (!npu_rst_n)                                   sat_count <= '0;
    else if (sat_clr)                                 sat_count <= '0;
    else if (dout_valid && dout_ready && sat_p2 && (sat_count != 16'hFFFF))
                                                      sat_count <= sat_count + 16'd1;
  end
`else
  logic unused_satcnt;
  assign sat_count     = '0;
  assign unused_satcnt = sat_clr ^ sat_p2;
`endif

endmodule

// File: tb/tb_npu_activation_unit.sv
// Directed scoreboard bench for npu_activation_unit: issued beats push their expected result,
// an output monitor pops and compares on every accepted output beat.
module tb_npu_activation_unit;
  import npu_act_pkg::*;

  logic               CLK = 1'b0;
  logic               npu_rst_n;
  logic signed [47:0] din;
  logic [1:0]         din_mode;
  logic [2:0]         din_ch;
  logic               din_valid;
  logic               din_ready;
  logic [15:0]        dout;
  logic [2:0]         dout_ch;
  logic               dout_valid;
  logic               dout_ready;
  logic               sat_clr;
  logic [15:0]        sat_count;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] d;
    bit          clamp;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   exp_cnt = 0;

  npu_activation_unit dut (
    .CLK        (CLK),
    .npu_rst_n  (npu_rst_n),
    .din        (din),
    .din_mode   (din_mode),
    .din_ch     (din_ch),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_clr    (sat_clr),
    .sat_count  (sat_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: an output beat transfers at the next posedge when valid & ready at the negedge.
  always @(negedge CLK) begin
    if (npu_rst_n && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {29'd0, dout_ch}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout_ch", {29'd0, dout_ch}, {29'd0, e.ch});
        check("dout",    {16'd0, dout},    {16'd0, e.d});
        if (e.clamp) exp_cnt++;
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic signed [47:0] d, input logic [2:0] c,
                      input logic [15:0] e, input bit clamp);
    int w;
    din       = d;
    din_mode  = m;
    din_ch    = c;
    din_valid = 1'b1;
    sb.push_back('{c, e, clamp});
    w = 0;
    @(negedge CLK);
    while (!din_ready && w < 100) begin
      w++;
      @(negedge CLK);
    end
    check("din_ready_accept", {31'd0, din_ready}, 32'd1);
    @(posedge CLK);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge CLK);
      w++;
    end
    check("drain_empty", sb.size(), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic check_count(input string nm);
`ifdef NPU_ACT_SATCNT_EN
    check(nm, {16'd0, sat_count}, exp_cnt);
`else
    check(nm, {16'd0, sat_count}, 32'd0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    npu_rst_n  = 1'b0;
    din        = '0;
    din_mode   = ACT_TANH;
    din_ch     = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    sat_clr    = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout",       {16'd0, dout},       32'd0);
    check("rst_sat_count",  {16'd0, sat_count},  32'd0);
    @(negedge CLK);
    npu_rst_n = 1'b1;
    @(posedge CLK);
    #1;
    check("rel_din_ready", {31'd0, din_ready}, 32'd1);

    // Linear latency on an idle pipe: valid appears two cycles after the accept cycle.
    send(ACT_LIN, 48'sh380, 3'd1, 16'h0007, 1'b0);
    check("lat_not_yet", {31'd0, dout_valid}, 32'd0);
    @(posedge CLK);
    #1;
    check("lat_valid", {31'd0, dout_valid}, 32'd1);
    check("lat_dout",  {16'd0, dout},       32'h0007);
    drain();

    // Linear
    send(ACT_LIN,  48'sh0100_0000,    3'd2, 16'h7FFF, 1'b1);
    send(ACT_LIN, -48'sh0100_0000,    3'd3, 16'h8000, 1'b1);
    send(ACT_LIN, -48'sh380,          3'd4, 16'hFFF9, 1'b0);
    send(ACT_LIN, -48'sh381,          3'd5, 16'hFFF8, 1'b0);
    send(ACT_LIN,  48'sh8000_0000_0000, 3'd6, 16'h8000, 1'b1);
    // Tanh
    send(ACT_TANH,  48'sh1_0000,      3'd0, 16'h0080, 1'b1);
    send(ACT_TANH, -48'sh1_0000,      3'd1, 16'hFF80, 1'b1);
    send(ACT_TANH,  48'sh0,           3'd2, 16'h0000, 1'b0);
    send(ACT_TANH, -48'sh400,         3'd3, 16'hFFF8, 1'b0);
    send(ACT_TANH,  48'sh400,         3'd4, 16'h0008, 1'b0);
    send(ACT_TANH,  48'sh4000,        3'd5, 16'h0061, 1'b0);
    send(ACT_TANH,  48'shC7A1,        3'd6, 16'h0080, 1'b1);
    send(ACT_TANH,  48'sh8000_0000_0000, 3'd7, 16'hFF80, 1'b1);
    // Relu
    send(ACT_RELU, -48'sh80,          3'd0, 16'h0000, 1'b0);
    send(ACT_RELU,  48'sh380,         3'd1, 16'h0007, 1'b0);
    send(ACT_RELU,  48'sh0100_0000,   3'd2, 16'h7FFF, 1'b1);
    // Logistic
    send(ACT_LOGI,  48'sh0,           3'd3, 16'h0040, 1'b0);
    send(ACT_LOGI,  48'sh10_0000,     3'd4, 16'h0080, 1'b1);
    send(ACT_LOGI,  48'sh8000,        3'd5, 16'h0070, 1'b0);
    send(ACT_LOGI, -48'sh8000,        3'd6, 16'h000F, 1'b0);
    send(ACT_LOGI, -48'sh10_0000,     3'd7, 16'h0000, 1'b1);
    drain();
    check_count("sat_count_total");

    sat_clr = 1'b1;
    @(posedge CLK);
    #1;
    sat_clr = 1'b0;
    exp_cnt = 0;
    check("sat_count_clr", {16'd0, sat_count}, 32'd0);

    // Backpressure: six back-to-back beats, output stalled for cycles 3..5.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send(ACT_LIN, 48'(k) <<< 7, 3'(k), 16'(k), 1'b0);
        end
      end
      begin
        repeat (3) @(posedge CLK);
        #1;
        dout_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge CLK);
          check("stall_din_ready",  {31'd0, din_ready},  32'd0);
          check("stall_dout_valid", {31'd0, dout_valid}, 32'd1);
          @(posedge CLK);
          #1;
        end
        dout_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: beats in flight are discarded.
    send(ACT_LIN, 48'sh380,         3'd2, 16'h0007, 1'b0);
    send(ACT_LIN, 48'sh0100_0000,   3'd3, 16'h7FFF, 1'b1);
    #2;
    npu_rst_n = 1'b0;
    #1;
    sb.delete();
    exp_cnt = 0;
    check("mid_rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst_dout",       {16'd0, dout},       32'd0);
    check("mid_rst_sat_count",  {16'd0, sat_count},  32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    npu_rst_n = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rel_din_ready",  {31'd0, din_ready},  32'd1);
    check("mid_rel_dout_valid", {31'd0, dout_valid}, 32'd0);
    send(ACT_LOGI, 48'sh0, 3'd5, 16'h0040, 1'b0);
    drain();
    check_count("sat_count_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
